// File: rtl/pronoc_jtag_probe_capture_if.sv
// Source/probe side bundle for the probe capture unit: control word in,
// monitored vector in, status word and trigger pulse out.
interface pronoc_jtag_probe_capture_if #(
  parameter int unsigned SIGw = 16,
  parameter int unsigned CNTw = 16
);
  localparam int unsigned CTRLw = SIGw + 4;
  localparam int unsigned STATw = SIGw + CNTw + 2;

  logic [CTRLw-1:0] ctrl_i;
  logic [SIGw-1:0]  sig_i;
  logic [STATw-1:0] status_o;
  logic             trig_o;

  // master: source/probe and logic-under-debug side; slave: capture unit
  modport master (output ctrl_i, output sig_i, input status_o, input trig_o);
  modport slave  (input ctrl_i, input sig_i, output status_o, output trig_o);
endinterface

// File: rtl/pronoc_jtag_probe_capture.sv
// Triggered snapshot unit: armed over JTAG source/probe, freezes one sample of
// sig_i plus the arm-to-trigger cycle count when the masked condition fires.
module pronoc_jtag_probe_capture #(
  parameter int unsigned SIGw = 16,
  parameter int unsigned CNTw = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  pronoc_jtag_probe_capture_if.slave bus
);

  localparam int unsigned CTRLw = SIGw + 4;

  localparam logic [1:0] MODE_LEVEL   = 2'b00;
  localparam logic [1:0] MODE_RISING  = 2'b01;
  localparam logic [1:0] MODE_IMMED   = 2'b10;
  localparam logic [1:0] MODE_FALLING = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_ARMED    = 2'b01,
    ST_CAPTURED = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [CTRLw-1:0]  ctrl_r_q, ctrl_r_d;
  logic [1:0]        ctrl_prev_q, ctrl_prev_d;
  logic [SIGw-1:0]   sig_r_q, sig_r_d;
  logic [SIGw-1:0]   sig_prev_q, sig_prev_d;
  logic [SIGw-1:0]   snap_q, snap_d;
  logic [CNTw-1:0]   cnt_q, cnt_d;
  logic              first_q, first_d;
  logic              trig_q, trig_d;

  logic              arm_p;
  logic              clr_p;
  logic [1:0]        mode;
  logic [SIGw-1:0]   mask;
  logic              hit;

  // Only the command bits need a second stage; the rest is read live
  assign arm_p = ctrl_r_q[0] & ~ctrl_prev_q[0];
  assign clr_p = ctrl_r_q[1] & ~ctrl_prev_q[1];
  assign mode  = ctrl_r_q[3:2];
  assign mask  = ctrl_r_q[CTRLw-1:4];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ctrl_r_q    <= '0;
      ctrl_prev_q <= '0;
      sig_r_q     <= '0;
      sig_prev_q  <= '0;
      snap_q      <= '0;
      cnt_q       <= '0;
      first_q     <= 1'b0;
      trig_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_r_q    <= ctrl_r_d;
      ctrl_prev_q <= ctrl_prev_d;
      sig_r_q     <= sig_r_d;
      sig_prev_q  <= sig_prev_d;
      snap_q      <= snap_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      trig_q      <= trig_d;
    end
  end

  always_comb begin
    ctrl_r_d    = bus.ctrl_i;
    ctrl_prev_d = ctrl_r_q[1:0];
    sig_r_d     = bus.sig_i;
    sig_prev_d  = sig_r_q;
    state_d     = state_q;
    snap_d      = snap_q;
    cnt_d       = cnt_q;
    first_d     = 1'b0;
    trig_d      = 1'b0;
    hit         = 1'b0;

    // Immediate mode fires only on the cycle right after the arm edge
    case (mode)
      MODE_LEVEL:   hit = |(sig_r_q & mask);
      MODE_RISING:  hit = |(sig_r_q & ~sig_prev_q & mask);
      MODE_IMMED:   hit = first_q;
      MODE_FALLING: hit = |(~sig_r_q & sig_prev_q & mask);
      default:      hit = 1'b0;
    endcase

    if (clr_p) begin
      state_d = ST_IDLE;
      snap_d  = '0;
      cnt_d   = '0;
    end else if (arm_p) begin
      state_d = ST_ARMED;
      cnt_d   = '0;
      first_d = 1'b1;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (hit) begin
            state_d = ST_CAPTURED;
            snap_d  = sig_r_q;
            trig_d  = 1'b1;
          end else if (cnt_q != {CNTw{1'b1}}) begin
            cnt_d = cnt_q + CNTw'(1);
          end
        end
        ST_CAPTURED: state_d = ST_CAPTURED;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.status_o = {cnt_q, snap_q, state_q};
  assign bus.trig_o   = trig_q;

endmodule

// File: tb/tb_pronoc_jtag_probe_capture.sv
// Bench for pronoc_jtag_probe_capture: two instances (CNTw 16 and 4) share the
// same stimulus and are compared every clock against a history-based model.
module tb_pronoc_jtag_probe_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] ctrl;
  logic [15:0] sig;

  int passed = 0;
  int total  = 0;
  int trig_seen = 0;

  // Reference model: plain counters plus a history of sampled inputs
  int unsigned     m_st;
  logic [15:0]     m_snap;
  longint unsigned m_cnt;
  logic            m_trig;
  logic            m_first;
  logic [19:0]     ch[$];
  logic [15:0]     sh[$];

  pronoc_jtag_probe_capture_if #(.SIGw(16), .CNTw(16)) ifa ();
  pronoc_jtag_probe_capture_if #(.SIGw(16), .CNTw(4))  ifb ();

  assign ifa.ctrl_i = ctrl;
  assign ifa.sig_i  = sig;
  assign ifb.ctrl_i = ctrl;
  assign ifb.sig_i  = sig;

  pronoc_jtag_probe_capture #(.SIGw(16), .CNTw(16)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave));
  pronoc_jtag_probe_capture #(.SIGw(16), .CNTw(4)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] exp_stat(input int w);
    longint unsigned mx;
    longint unsigned c;
    mx = (64'd1 << w) - 64'd1;
    c  = (m_cnt > mx) ? mx : m_cnt;
    return (64'(c) << 18) | (64'(m_snap) << 2) | 64'(m_st);
  endfunction

  // One clock: update model at the edge, compare both instances at negedge
  task automatic tick();
    logic        arm;
    logic        clr;
    logic [1:0]  mode;
    logic [15:0] mask;
    logic        hit;
    @(posedge clk);
    if (reset) begin
      m_st = 0; m_snap = '0; m_cnt = 0; m_trig = 1'b0; m_first = 1'b0;
      ch.push_front('0);
      sh.push_front('0);
    end else begin
      arm  = ch[0][0] && !ch[1][0];
      clr  = ch[0][1] && !ch[1][1];
      mode = ch[0][3:2];
      mask = ch[0][19:4];
      m_trig = 1'b0;
      if (clr) begin
        m_st = 0; m_snap = '0; m_cnt = 0;
      end else if (arm) begin
        m_st = 1; m_cnt = 0; m_first = 1'b1;
      end else if (m_st == 1) begin
        case (mode)
          2'd0:    hit = |(sh[0] & mask);
          2'd1:    hit = |(sh[0] & ~sh[1] & mask);
          2'd2:    hit = m_first;
          default: hit = |(~sh[0] & sh[1] & mask);
        endcase
        m_first = 1'b0;
        if (hit) begin
          m_st = 2; m_snap = sh[0]; m_trig = 1'b1;
        end else begin
          m_cnt++;
        end
      end
      ch.push_front(ctrl);
      sh.push_front(sig);
    end
    while (ch.size() > 4) void'(ch.pop_back());
    while (sh.size() > 4) void'(sh.pop_back());
    @(negedge clk);
    check("status_a", 64'(ifa.status_o), exp_stat(16));
    check("status_b", 64'(ifb.status_o), exp_stat(4));
    check("trig_a", 64'(ifa.trig_o), 64'(m_trig));
    check("trig_b", 64'(ifb.trig_o), 64'(m_trig));
    if (ifa.trig_o) trig_seen++;
  endtask

  initial begin
    m_st = 0; m_snap = '0; m_cnt = 0; m_trig = 1'b0; m_first = 1'b0;
    ch.push_front('0); ch.push_front('0);
    sh.push_front('0); sh.push_front('0);

    // Arm bit held through reset: armed two clocks after release
    reset = 1'b1; ctrl = 20'h1; sig = '0;
    repeat (3) tick();
    check("reset_status", 64'(ifa.status_o), 64'd0);
    reset = 1'b0;
    tick();
    check("arm_not_yet", 64'(ifa.status_o[1:0]), 64'd0);
    tick();
    check("arm_thru_reset", 64'(ifa.status_o[1:0]), 64'd1);
    ctrl = 20'h0; tick();
    ctrl = 20'h2; repeat (2) tick();
    check("clear_idle", 64'(ifa.status_o[1:0]), 64'd0);

    // Immediate mode
    ctrl = 20'h8; sig = 16'hA5A5; repeat (2) tick();
    trig_seen = 0;
    ctrl = 20'h9; repeat (5) tick();
    check("imm_state", 64'(ifa.status_o[1:0]), 64'd2);
    check("imm_snap", 64'(ifa.status_o[17:2]), 64'hA5A5);
    check("imm_cnt", 64'(ifa.status_o[33:18]), 64'd0);
    check("imm_trig_once", 64'(trig_seen), 64'd1);

    // Rising mode, bit0 first high on the 10th clock after ARMED entry
    ctrl = 20'h14; sig = 16'($urandom) & 16'hFFFE; repeat (2) tick();
    ctrl = 20'h15;
    repeat (11) begin sig = 16'($urandom) & 16'hFFFE; tick(); end
    sig = 16'($urandom) | 16'h0001; repeat (3) tick();
    check("rise_state", 64'(ifa.status_o[1:0]), 64'd2);
    check("rise_cnt", 64'(ifa.status_o[33:18]), 64'd10);
    check("rise_bit0", 64'(ifa.status_o[2]), 64'd1);
    repeat (6) begin sig = 16'($urandom); tick(); end
    check("rise_cnt_hold", 64'(ifa.status_o[33:18]), 64'd10);

    // Falling mode on bit 15
    ctrl = 20'h8000C; sig = 16'hFFFF; repeat (2) tick();
    ctrl = 20'h8000D; repeat (4) tick();
    sig = 16'h7FFF; repeat (3) tick();
    check("fall_state", 64'(ifa.status_o[1:0]), 64'd2);
    check("fall_snap", 64'(ifa.status_o[17:2]), 64'h7FFF);

    // Level mode with the condition already present at arm
    ctrl = 20'h0F000; sig = 16'h0100; repeat (2) tick();
    ctrl = 20'h0F001; repeat (3) tick();
    check("lvl_state", 64'(ifa.status_o[1:0]), 64'd2);
    check("lvl_cnt", 64'(ifa.status_o[33:18]), 64'd0);
    check("lvl_snap", 64'(ifa.status_o[17:2]), 64'h0100);

    // Clear while armed with a mask that can never fire
    ctrl = 20'h0; repeat (2) tick();
    trig_seen = 0;
    ctrl = 20'h1;
    repeat (7) begin sig = 16'($urandom); tick(); end
    ctrl = 20'h3; repeat (2) tick();
    check("clr_status", 64'(ifa.status_o), 64'd0);
    check("clr_no_trig", 64'(trig_seen), 64'd0);

    // Arm and clear edges together
    ctrl = 20'h1; repeat (2) tick();
    ctrl = 20'h0; tick();
    ctrl = 20'h3; repeat (2) tick();
    check("arm_clr_same", 64'(ifa.status_o[1:0]), 64'd0);

    // Saturation of the narrow counter, then restart on re-arm
    ctrl = 20'h0; tick();
    ctrl = 20'h1;
    repeat (40) begin sig = 16'($urandom); tick(); end
    check("sat_cnt_b", 64'(ifb.status_o[21:18]), 64'hF);
    check("sat_state_b", 64'(ifb.status_o[1:0]), 64'd1);
    ctrl = 20'h0; tick();
    ctrl = 20'h1; repeat (2) tick();
    check("rearm_cnt_b", 64'(ifb.status_o[21:18]), 64'd0);

    // Reset while armed, then while captured
    reset = 1'b1; tick();
    check("rst_armed", 64'(ifa.status_o), 64'd0);
    reset = 1'b0; ctrl = 20'h8; repeat (2) tick();
    ctrl = 20'h9; repeat (4) tick();
    check("pre_rst_capt", 64'(ifa.status_o[1:0]), 64'd2);
    reset = 1'b1; tick();
    check("rst_capt", 64'(ifa.status_o), 64'd0);
    check("rst_capt_b", 64'(ifb.status_o), 64'd0);
    reset = 1'b0;

    // Randomised phase: sparse command edges, live mode/mask changes
    repeat (400) begin
      if ($urandom_range(0, 7) == 0) ctrl[0] = ~ctrl[0];
      if ($urandom_range(0, 23) == 0) ctrl[1] = ~ctrl[1];
      if ($urandom_range(0, 15) == 0) ctrl[3:2] = 2'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 2))
          0:       ctrl[19:4] = 16'd0;
          1:       ctrl[19:4] = 16'd1 << $urandom_range(0, 15);
          default: ctrl[19:4] = 16'($urandom);
        endcase
      end
      sig = ($urandom_range(0, 1) == 0) ? 16'($urandom) : sig;
      reset = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pronoc_jtag_probe_capture.md
# pronoc_jtag_probe_capture

Triggered snapshot unit placed between a JTAG source/probe instance and the logic under debug. It takes its control word from the source/probe `source_o` output and returns its status word into `probe_i`. The host arms it over JTAG, it watches a signal vector for a masked trigger condition, and on trigger it freezes one snapshot plus the arm-to-trigger cycle count. Everything runs in the `clk` domain, the same domain as the source/probe register, so no CDC is needed.

## Interface
- `SIGw`, default 16: width of monitored vector, snapshot and trigger mask.
- `CNTw`, default 16: width of the arm-to-trigger cycle counter (saturating).
- `CTRLw`, default SIGw+4: control word width. Fixed, not overridable. Connect to source/probe `Dw`.
- `STATw`, default SIGw+CNTw+2: status word width. Fixed. Status and control together set the source/probe `Dw` ≥ max(CTRLw, STATw).
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `ctrl_i`, in, CTRLw: control word from source/probe `source_o`.
  - [0] arm: acts on 0→1 edge.
  - [1] clear: acts on 0→1 edge.
  - [3:2] mode: 00 level, 01 rising, 10 immediate, 11 falling.
  - [SIGw+3:4] trigger mask.
- `sig_i`, in, SIGw: monitored signals, synchronous to clk.
- `status_o`, out, STATw: goes to source/probe `probe_i`. Layout {cnt, snapshot, state[1:0]}.
- `trig_o`, out, 1: one-cycle pulse on the clock that enters CAPTURED.

## Operation
- Input registers, always running: ctrl_r ← ctrl_i, ctrl_q ← ctrl_r, sig_r ← sig_i, sig_q ← sig_r.
- Command pulses:
  - arm_p = ctrl_r[0] & ~ctrl_q[0].
  - clr_p = ctrl_r[1] & ~ctrl_q[1].
- Mode and mask are read live from ctrl_r.
- Trigger condition, evaluated only in ARMED, with m = mask:
  - 00 level: |(sig_r & m).
  - 01 rising: |(sig_r & ~sig_q & m).
  - 11 falling: |(~sig_r & sig_q & m).
  - 10 immediate: 1 on the first ARMED cycle.
- A mask of 0 never triggers in modes 00, 01 and 11.
- State encoding: IDLE=00, ARMED=01, CAPTURED=10. Code 11 is never output.
- Transitions, in priority order:
  - clr_p, from any state → IDLE. snapshot=0, cnt=0.
  - arm_p, from any state → ARMED. cnt=0. snapshot is kept until the next capture.
  - ARMED & trigger → CAPTURED. snapshot ← sig_r, trig_o=1. cnt holds.
  - ARMED & no trigger → ARMED. cnt ← cnt+1, saturating at all-ones with no wrap.
  - CAPTURED holds until arm_p or clr_p.
  - IDLE holds.
- Simultaneous arm and clear edges: clear wins, result IDLE.
- Arm while ARMED restarts the count at 0. Arm while CAPTURED re-arms.
- Trigger and arm_p on the same cycle: arm_p wins, no capture.
- The edge pair sig_r/sig_q is valid from the first ARMED cycle. An edge present on that cycle triggers.

## Timing
- Reset values: state IDLE, snapshot 0, cnt 0, trig_o 0, all input registers 0.
- If ctrl_i[0]=1 while reset is asserted, an arm edge is seen 2 clocks after reset deassert. This is required behaviour.
- ctrl_i edge to state change: ctrl_i sampled new at clock t gives state updated at clock t+1, visible on status_o after t+1.
- sig_i to snapshot: a value sampled at clock k is captured at clock k+1 if it triggers.
- status_o and trig_o are driven straight from registers; there is no combinational path from inputs.
- cnt equals the number of ARMED clocks that did not trigger. Immediate mode gives cnt=0.
- The JTAG host reads status_o asynchronously relative to updates. Multi-bit tearing is acceptable because the host polls state==10 first and then rereads.

## Test plan
- Immediate mode: ctrl=mode 10, then arm 0→1 → ARMED for 1 clock, then CAPTURED. trig_o pulses once, cnt=0, snapshot = sig_i sampled on the ARMED entry clock (drive 0xA5A5 → snapshot 0xA5A5).
- Rising mode, mask 0x0001, sig_i[0] first sampled high at the 10th clock after ARMED → cnt=10, snapshot bit0=1, state=10. Later sig_i toggles leave snapshot and cnt unchanged.
- Falling mode, mask 0x8000, sig_i=0xFFFF, then 0x7FFF → capture 0x7FFF. Level mode, mask 0x0F00, sig_i=0x0100 already present at arm → capture on the first ARMED clock, cnt=0.
- Clear mid-ARMED at cnt≈5 → IDLE, cnt=0, snapshot=0, no trig_o. Arm and clear rising on the same clock → IDLE.
- CNTw=4, mask=0, mode 00, armed for 40 clocks → cnt=15 held, state stays 01. Re-arm → cnt=0.
- Reset asserted mid-ARMED and mid-CAPTURED → all outputs 0 on the next clock. Arm bit held high through reset → ARMED 2 clocks after deassert.
